page_mem_ctrl: RTL and testbench

PAGE_MEM_CTRL -- requirements
Module: page_mem_ctrl

---
 rtl/page_mem_ctrl.sv | 81 ++++++++
 tb/tb_page_mem_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/page_mem_ctrl.sv
// page_mem_ctrl: word memory cleared by a power-up sweep, then serving READ/WRITE/XCHG
// requests with a one-cycle registered response and ready/valid backpressure.
module page_mem_ctrl #(
    parameter int                DATA_W   = 12,
    parameter int                ADDR_W   = 12,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              init_done
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_XCHG = 2'b10, OP_RSVD = 2'b11;

    typedef enum logic {INIT, RUN} state_t;

    state_t              r_state, w_state_nx;
    logic [ADDR_W:0]     r_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                r_resp_valid, r_resp_err;
    logic [DATA_W-1:0]   r_resp_data;
    logic                w_accept, w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_wdata;

    always_comb begin
        w_state_nx = (r_state == INIT && r_cnt == LAST) ? RUN : r_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= INIT;
        else        r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                r_cnt <= '0;
        else if (r_state == INIT)  r_cnt <= r_cnt + 1'b1;
    end

    assign req_ready = (r_state == RUN) && (!r_resp_valid || resp_ready);
    assign w_accept  = req_valid && req_ready;
    assign init_done = (r_state == RUN);

    // The sweep and request writes share one port; the sweep owns it until RUN.
    assign w_we    = rst_n && ((r_state == INIT) || (w_accept && (req_op == OP_WR || req_op == OP_XCHG)));
    assign w_waddr = (r_state == INIT) ? r_cnt[ADDR_W-1:0] : req_addr;
    assign w_wdata = (r_state == INIT) ? INIT_VAL : req_wdata;

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    // Response captures pre-write contents, which gives XCHG its displacement value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= (req_op == OP_RD || req_op == OP_XCHG) ? r_mem[req_addr] : '0;
            r_resp_err   <= (req_op == OP_RSVD);
        end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
endmodule

// File: tb/tb_page_mem_ctrl.sv
// tb_page_mem_ctrl: directed scenarios checked against a cycle model of the request/response rules.
module tb_page_mem_ctrl;
    localparam int DW = 12, AW = 4, DEPTH = 16;

    logic          clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, resp_ready = 1'b1;
    logic [1:0]    req_op = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, resp_valid, resp_err, init_done;
    logic [DW-1:0] resp_data;

    int n_chk = 0, n_err = 0;

    page_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL('0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sweep counts cycles since reset, responses follow the op table directly.
    logic          m_known = 1'b0, m_run = 1'b0, m_rv = 1'b0, m_re = 1'b0;
    logic [DW-1:0] m_rd = '0;
    logic [DW-1:0] m_mem [DEPTH];
    int            m_sweep = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_known <= 1'b1; m_run <= 1'b0; m_sweep <= 0;
            m_rv <= 1'b0; m_rd <= '0; m_re <= 1'b0;
        end else if (m_known) begin
            if (!m_run) begin
                m_mem[m_sweep] <= '0;
                m_sweep <= m_sweep + 1;
                m_run <= (m_sweep + 1 == DEPTH);
            end else if (req_valid && (!m_rv || resp_ready)) begin
                m_rv <= 1'b1;
                m_re <= (req_op == 2'd3);
                m_rd <= (req_op == 2'd0 || req_op == 2'd2) ? m_mem[req_addr] : '0;
                if (req_op == 2'd1 || req_op == 2'd2) m_mem[req_addr] <= req_wdata;
            end else if (resp_ready) begin
                m_rv <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("model_req_ready", 32'(req_ready), 32'(m_run && (!m_rv || resp_ready)));
            chk("model_init_done", 32'(init_done), 32'(m_run));
            chk("model_resp_valid", 32'(resp_valid), 32'(m_rv));
            chk("model_resp_data", 32'(resp_data), 32'(m_rd));
            chk("model_resp_err", 32'(resp_err), 32'(m_re));
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
    endtask

    task automatic count_sweep(input string name);
        int n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
        end
        chk({name, "_cycles"}, 32'(n), 32'd16);
        chk({name, "_done"}, 32'(init_done), 32'd1);
        step();
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        count_sweep(name);
    endtask

    task automatic txn(input string name, input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp, input logic exp_err);
        issue(op, a, d);
        resp_ready = 1'b1;
        @(negedge clk);
        chk({name, "_ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, 32'(resp_valid), 32'd1);
        chk({name, "_data"}, 32'(resp_data), 32'(exp));
        chk({name, "_err"}, 32'(resp_err), 32'(exp_err));
        step();
    endtask

    initial begin
        do_reset("init");
        for (int i = 0; i < DEPTH; i++) txn("init_read", 2'd0, 4'(i), '0, 12'h000, 1'b0);

        // Back-to-back WRITE then READ of the same word
        issue(2'd1, 4'h5, 12'hABC);
        step();
        issue(2'd0, 4'h5, 12'h000);
        @(negedge clk);
        chk("wr_resp_data", 32'(resp_data), 32'h000);
        chk("wr_next_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("rd_after_wr_valid", 32'(resp_valid), 32'd1);
        chk("rd_after_wr_data", 32'(resp_data), 32'hABC);
        step();

        txn("xchg_seed", 2'd1, 4'h3, 12'h111, 12'h000, 1'b0);
        txn("xchg", 2'd2, 4'h3, 12'h222, 12'h111, 1'b0);
        txn("xchg_readback", 2'd0, 4'h3, 12'h000, 12'h222, 1'b0);

        // Backpressure: response held while the next request waits
        resp_ready = 1'b0;
        issue(2'd0, 4'h5, 12'h000);
        step();
        issue(2'd0, 4'h3, 12'h000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready_low", 32'(req_ready), 32'd0);
            chk("bp_valid_held", 32'(resp_valid), 32'd1);
            chk("bp_data_stable", 32'(resp_data), 32'hABC);
            step();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", 32'(resp_valid), 32'd1);
        chk("bp_next_data", 32'(resp_data), 32'h222);
        step();
        @(negedge clk);
        chk("bp_valid_falls", 32'(resp_valid), 32'd0);
        step();

        txn("rsvd_seed", 2'd1, 4'h7, 12'h777, 12'h000, 1'b0);
        txn("rsvd", 2'd3, 4'h7, 12'hFFF, 12'h000, 1'b1);
        txn("rsvd_mem_kept", 2'd0, 4'h7, 12'h000, 12'h777, 1'b0);

        // Reset while a response is pending
        resp_ready = 1'b0;
        issue(2'd0, 4'h7, 12'h000);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("pend_valid", 32'(resp_valid), 32'd1);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        count_sweep("resweep");
        txn("after_rst_rd7", 2'd0, 4'h7, 12'h000, 12'h000, 1'b0);

        txn("seed5", 2'd1, 4'h5, 12'h5A5, 12'h000, 1'b0);
        // Reset again once the sweep counter has reached 8
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (8) step();
        do_reset("midsweep");
        txn("after_mid_rd5", 2'd0, 4'h5, 12'h000, 12'h000, 1'b0);
        txn("after_mid_rd3", 2'd0, 4'h3, 12'h000, 12'h000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
